// File: rtl/sift_orient_pkg.sv
// Shared constants, FSM state type and saturating-add helper for the
// orientation histogram peak finder.
package sift_orient_pkg;

  localparam int DIR_W = 5;
  localparam int NBINS = 1 << DIR_W;
  localparam int MAG_W = 8;
  localparam int ACC_W = 16;

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Unsigned accumulate that clamps at ACC_MAX instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [MAG_W-1:0] mag);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W + 1 - MAG_W){1'b0}}, mag};
    return sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/orient_hist_peak_if.sv
// Sample-in / result-out handshake bundle for orient_hist_peak.
interface orient_hist_peak_if;
  import sift_orient_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [DIR_W-1:0] s_dir;
  logic [MAG_W-1:0] s_mag;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [DIR_W-1:0] m_bin;
  logic [ACC_W-1:0] m_peak;

  modport slave (
    input  s_valid, s_dir, s_mag, s_last, m_ready,
    output s_ready, m_valid, m_bin, m_peak
  );

  modport master (
    output s_valid, s_dir, s_mag, s_last, m_ready,
    input  s_ready, m_valid, m_bin, m_peak
  );

endinterface

// File: rtl/orient_hist_bank.sv
// 32-entry flop register file of saturating per-bin accumulators with an
// indexed read port and a single-cycle clear of every bin.
module orient_hist_bank
  import sift_orient_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DIR_W-1:0] wr_idx,
  input  logic [MAG_W-1:0] wr_mag,
  input  logic             clr,
  input  logic [DIR_W-1:0] rd_idx,
  output logic [ACC_W-1:0] rd_data
);

  logic [ACC_W-1:0] bins_q [NBINS];
  logic [ACC_W-1:0] wr_sum_d;

  assign wr_sum_d = sat_add(bins_q[wr_idx], wr_mag);
  assign rd_data  = bins_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
    end else if (wr_en) begin
      bins_q[wr_idx] <= wr_sum_d;
    end
  end

endmodule

// File: rtl/orient_hist_peak.sv
// Orientation histogram: accumulate a keypoint window, scan for the dominant
// bin, then hold {bin, peak} until the descriptor stage takes it.
module orient_hist_peak
  import sift_orient_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  orient_hist_peak_if.slave bus
);

  state_t           state_q, state_d;
  logic [DIR_W:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0] rd_q, rd_d;
  logic [ACC_W-1:0] best_q, best_d;
  logic [DIR_W-1:0] best_idx_q, best_idx_d;
  logic [ACC_W-1:0] rd_data;
  logic             wr_en, clr, s_ready, m_valid;

  orient_hist_bank u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_idx (bus.s_dir),
    .wr_mag (bus.s_mag),
    .clr    (clr),
    .rd_idx (cnt_q[DIR_W-1:0]),
    .rd_data(rd_data)
  );

  // Scan reads are registered into rd_q and compared one cycle later, so
  // cnt runs 0..NBINS: step k loads bin k and judges bin k-1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    wr_en      = 1'b0;
    clr        = 1'b0;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    case (state_q)
      ST_ACC: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          wr_en = 1'b1;
          if (bus.s_last) begin
            state_d    = ST_SCAN;
            cnt_d      = '0;
            best_d     = '0;
            best_idx_d = '0;
          end
        end
      end
      ST_SCAN: begin
        if (!cnt_q[DIR_W]) rd_d = rd_data;
        if (cnt_q != '0 && rd_q > best_q) begin
          best_d     = rd_q;
          best_idx_d = cnt_q[DIR_W-1:0] - DIR_W'(1);
        end
        cnt_d = cnt_q + (DIR_W + 1)'(1);
        if (cnt_q[DIR_W]) state_d = ST_OUT;
      end
      ST_OUT: begin
        m_valid = 1'b1;
        if (bus.m_ready) begin
          clr        = 1'b1;
          state_d    = ST_ACC;
          best_d     = '0;
          best_idx_d = '0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACC;
      cnt_q      <= '0;
      rd_q       <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_bin   = best_idx_q;
  assign bus.m_peak  = best_q;

endmodule
